pipeline_hazard_controller: RTL
===============================

Name: pipeline_hazard_controller

Overview:
- Central stall/flush controller for the RV32I 5-stage pipeline (IF, ID, EX, MEM, WB).
- Generates per-stage register enables and flushes for three cases: load-use hazards, taken branches/jumps resolved in EX, and multi-cycle data-memory handshakes.
- Contains a small FSM for memory waits with a timeout error state, plus a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register-index width
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before error (>=2)
CNT_W, 32, stall counter width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
id_rs1  in  REG_ADDR_W  rs1 of instruction in ID
id_rs2  in  REG_ADDR_W  rs2 of instruction in ID
id_uses_rs2  in  1  ID instruction reads rs2 (R, S, SB types)
ex_rd  in  REG_ADDR_W  destination of instruction in EX
ex_load  in  1  EX instruction is a load (decoder load flag)
ex_valid  in  1  EX holds a real instruction (not a bubble)
branch_taken  in  1  EX redirects PC (taken branch, jal, jalr)
mem_access  in  1  MEM holds a valid load or store
dmem_ready  in  1  data memory completes the access this cycle
pc_enable  out  1  PC register load enable
if_id_enable  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID cleared to bubble
id_ex_enable  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX cleared to bubble
ex_mem_enable  out  1  EX/MEM register enable
mem_wb_flush  out  1  MEM/WB loaded with bubble
dmem_req  out  1  data memory request
mem_error  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  cycles with pc_enable=0 since reset

Behaviour:
- Outputs are combinational from the registered state and current inputs, with zero latency. State and counters update on the rising clk edge.
- While rst=1:
  - state=RUN; wait_cnt=0; stall_cycles=0; mem_error=0.
  - Outputs forced: all enables 0, if_id_flush=1, id_ex_flush=1, mem_wb_flush=1, dmem_req=0.
- Default (no event): all enables 1, all flushes 0, dmem_req=0.
- Load-use hazard condition: ex_valid & ex_load & ex_rd!=0 & (id_rs1==ex_rd | (id_uses_rs2 & id_rs2==ex_rd)).
- State RUN:
  - dmem_req=mem_access.
  - Memory stall (mem_access & ~dmem_ready):
    - pc_enable, if_id_enable, id_ex_enable, ex_mem_enable = 0; mem_wb_flush=1.
    - Next state MEM_WAIT, wait_cnt<=1.
  - Otherwise, if branch_taken: if_id_flush=1, id_ex_flush=1, pc_enable=1.
    - Branch wins over a simultaneous load-use hazard, because the ID instruction is squashed.
  - Otherwise, if load-use: pc_enable=0, if_id_enable=0, id_ex_flush=1 (one bubble).
  - Exactly one bubble per hazard: the next cycle the load is in MEM and the condition clears.
- State MEM_WAIT:
  - dmem_req=1 held regardless of mem_access.
  - If dmem_ready=1: normal RUN-cycle outputs are applied with the memory access treated as complete, including any branch_taken or load-use held in EX/ID; next state RUN, wait_cnt<=0.
  - Else, if wait_cnt==MEM_TIMEOUT-1: next state ERROR; stall outputs this cycle.
  - Else: stall outputs as above; wait_cnt<=wait_cnt+1.
  - branch_taken and load-use are ignored while stalled: EX/ID are frozen, so the condition persists and is acted on at release.
- State ERROR:
  - All enables 0, all flushes 0, dmem_req=0, mem_error=1.
  - Only rst exits ERROR.
- stall_cycles: increments each non-reset cycle with pc_enable=0; saturates at all-ones with no wrap.
- Reset asserted mid-MEM_WAIT or in ERROR: returns to RUN on the next edge; wait_cnt cleared.
- dmem_ready while mem_access=0 in RUN: ignored.

Test Plan:
- Load-use: ex_load=1, ex_valid=1, ex_rd=5, id_rs1=5 -> one cycle with pc_enable=0, if_id_enable=0, id_ex_flush=1; next cycle (ex_load=0) all enables 1; stall_cycles=1.
- rd=x0 and rs2 gating: ex_rd=0, id_rs1=0 -> no stall. Then ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall; id_uses_rs2=1 -> stall.
- Branch plus load-use same cycle: branch_taken=1 with hazard asserted -> if_id_flush=1, id_ex_flush=1, pc_enable=1, no stall.
- Memory wait: mem_access=1, dmem_ready=0 for 3 cycles then 1 -> dmem_req=1 for all 4 cycles; enables 0 and mem_wb_flush=1 for 3 cycles; release on the 4th; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, mem_access=1, dmem_ready never asserted -> ERROR entered after 4 stalled cycles; mem_error=1 and dmem_req=0 thereafter. rst for 1 cycle -> mem_error=0, state RUN, stall_cycles=0.
- Branch held during memory wait: branch_taken=1 throughout a 2-cycle wait -> no flush while stalled; if_id_flush=1 and id_ex_flush=1 on the dmem_ready cycle.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush control for the 5-stage RV32I pipeline
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_load,
  input  logic                  ex_valid,
  input  logic                  branch_taken,
  input  logic                  mem_access,
  input  logic                  dmem_ready,
  output logic                  pc_enable,
  output logic                  if_id_enable,
  output logic                  if_id_flush,
  output logic                  id_ex_enable,
  output logic                  id_ex_flush,
  output logic                  ex_mem_enable,
  output logic                  mem_wb_flush,
  output logic                  dmem_req,
  output logic                  mem_error,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              load_use;
  logic              mem_stall;

  // A load in EX feeding a source operand of the ID instruction; x0 never creates a dependency.
  assign load_use = ex_valid && ex_load && (ex_rd != '0) &&
                    ((id_rs1 == ex_rd) || (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Per-stage enables/flushes; memory stall outranks branch, branch outranks load-use.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_enable  = 1'b1;
    id_ex_flush   = 1'b0;
    ex_mem_enable = 1'b1;
    mem_wb_flush  = 1'b0;
    dmem_req      = 1'b0;
    mem_error     = 1'b0;
    mem_stall     = 1'b0;
    if (rst) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_flush  = 1'b1;
    end else if (state == ST_ERROR) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      id_ex_enable  = 1'b0;
      ex_mem_enable = 1'b0;
      mem_error     = 1'b1;
    end else begin
      if (state == ST_MEM_WAIT) begin
        // Request is held for the outstanding access even if MEM's valid flag dropped.
        dmem_req  = 1'b1;
        mem_stall = !dmem_ready;
      end else begin
        dmem_req  = mem_access;
        mem_stall = mem_access && !dmem_ready;
      end
      if (mem_stall) begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        mem_wb_flush  = 1'b1;
      end else if (branch_taken) begin
        // The ID instruction is squashed, so any load-use against it is moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_enable    = 1'b0;
        if_id_enable = 1'b0;
        id_ex_flush  = 1'b1;
      end
    end
  end

  // Memory-wait FSM: counts stalled cycles of one access and traps into ERROR on timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_stall) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (dmem_ready) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state    <= ST_ERROR;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_ERROR: begin
          state <= ST_ERROR;
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (!pc_enable && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
